// File: rtl/ysyx_23060240_idu_stage.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060240_idu_stage
// Brief    : Registered RV32I(+M) decode stage between IFU and EXU. Decodes one
//            instruction per cycle into a bundle register behind valid/ready
//            handshakes, with flush and an ebreak/illegal halt FSM.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060240_idu_stage #(
  parameter int XLEN            = 32,
  parameter bit ENABLE_M        = 1'b1,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_alu_a_sel,
  output logic            out_alu_b_sel,
  output logic [4:0]      out_alu_func,
  output logic            out_w_en,
  output logic [1:0]      out_w_sel,
  output logic            out_jump_en,
  output logic [2:0]      out_br_type,
  output logic            out_is_branch,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic [2:0]      out_mem_size,
  output logic            out_illegal,
  output logic            out_ebreak,
  output logic            halted
);

  localparam logic [6:0]  c_OP_LUI    = 7'b0110111;
  localparam logic [6:0]  c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  c_OP_JAL    = 7'b1101111;
  localparam logic [6:0]  c_OP_JALR   = 7'b1100111;
  localparam logic [6:0]  c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  c_OP_STORE  = 7'b0100011;
  localparam logic [6:0]  c_OP_IMM    = 7'b0010011;
  localparam logic [6:0]  c_OP_REG    = 7'b0110011;
  localparam logic [6:0]  c_OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] c_EBREAK    = 32'h0010_0073;

  localparam logic [1:0]  c_WSEL_NONE = 2'b00;
  localparam logic [1:0]  c_WSEL_PC4  = 2'b01;
  localparam logic [1:0]  c_WSEL_ALU  = 2'b10;
  localparam logic [1:0]  c_WSEL_MEM  = 2'b11;
  localparam logic [4:0]  c_ALU_ADD   = 5'b00000;
  localparam logic [4:0]  c_ALU_PASSB = 5'b01110;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e state_q, state_d;

  // instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       accept;
  logic       halt_evt;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  // decoded next-state values for the bundle register
  logic [31:0]     imm32_d;
  logic [XLEN-1:0] imm_d;
  logic            a_sel_d, b_sel_d;
  logic [4:0]      alu_func_d;
  logic            w_en_raw, mem_rd_raw, mem_wr_raw, jump_raw, is_br_raw;
  logic            w_en_d, mem_rd_d, mem_wr_d, jump_d, is_br_d;
  logic [1:0]      w_sel_d;
  logic            illegal_d, ebreak_d;

  // bundle registers
  logic            valid_q;
  logic [XLEN-1:0] pc_q, imm_q;
  logic [4:0]      rs1_q, rs2_q, rd_q, alu_func_q;
  logic            a_sel_q, b_sel_q, w_en_q, jump_q, is_br_q;
  logic            mem_rd_q, mem_wr_q, illegal_q, ebreak_q;
  logic [1:0]      w_sel_q;
  logic [2:0]      br_type_q, mem_size_q;

  assign in_ready = (state_q == ST_RUN) && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign ebreak_d = (in_inst == c_EBREAK);

  // Sign-extend the 32-bit immediate to the datapath width.
  assign imm_d = XLEN'($signed(imm32_d));

  // Decode opcode/funct fields into control, immediate and legality.
  always_comb begin
    imm32_d    = 32'h0;
    a_sel_d    = 1'b1;
    b_sel_d    = 1'b1;
    alu_func_d = c_ALU_ADD;
    w_en_raw   = 1'b0;
    w_sel_d    = c_WSEL_NONE;
    jump_raw   = 1'b0;
    is_br_raw  = 1'b0;
    mem_rd_raw = 1'b0;
    mem_wr_raw = 1'b0;
    illegal_d  = 1'b0;
    case (opcode)
      c_OP_LUI: begin
        imm32_d    = {in_inst[31:12], 12'h000};
        a_sel_d    = 1'b0;
        alu_func_d = c_ALU_PASSB;
        w_en_raw   = 1'b1;
        w_sel_d    = c_WSEL_ALU;
      end
      c_OP_AUIPC: begin
        imm32_d  = {in_inst[31:12], 12'h000};
        a_sel_d  = 1'b0;
        w_en_raw = 1'b1;
        w_sel_d  = c_WSEL_ALU;
      end
      c_OP_JAL: begin
        imm32_d  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                    in_inst[20], in_inst[30:21], 1'b0};
        a_sel_d  = 1'b0;
        w_en_raw = 1'b1;
        w_sel_d  = c_WSEL_PC4;
        jump_raw = 1'b1;
      end
      c_OP_JALR: begin
        imm32_d   = {{20{in_inst[31]}}, in_inst[31:20]};
        w_en_raw  = 1'b1;
        w_sel_d   = c_WSEL_PC4;
        jump_raw  = 1'b1;
        illegal_d = (funct3 != 3'b000);
      end
      c_OP_BRANCH: begin
        imm32_d   = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                     in_inst[30:25], in_inst[11:8], 1'b0};
        a_sel_d   = 1'b0;
        is_br_raw = 1'b1;
        illegal_d = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      c_OP_LOAD: begin
        imm32_d    = {{20{in_inst[31]}}, in_inst[31:20]};
        w_en_raw   = 1'b1;
        w_sel_d    = c_WSEL_MEM;
        mem_rd_raw = 1'b1;
        illegal_d  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      c_OP_STORE: begin
        imm32_d    = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        mem_wr_raw = 1'b1;
        illegal_d  = (funct3 > 3'b010);
      end
      c_OP_IMM: begin
        imm32_d    = {{20{in_inst[31]}}, in_inst[31:20]};
        w_en_raw   = 1'b1;
        w_sel_d    = c_WSEL_ALU;
        alu_func_d = {1'b0, (funct3 == 3'b101) && in_inst[30], funct3};
        if (funct3 == 3'b001) begin
          illegal_d = (funct7 != 7'h00);
        end else if (funct3 == 3'b101) begin
          illegal_d = (funct7 != 7'h00) && (funct7 != 7'h20);
        end
      end
      c_OP_REG: begin
        b_sel_d  = 1'b0;
        w_en_raw = 1'b1;
        w_sel_d  = c_WSEL_ALU;
        if (funct7 == 7'h00) begin
          alu_func_d = {2'b00, funct3};
        end else if ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
          alu_func_d = {2'b01, funct3};
        end else if ((funct7 == 7'h01) && ENABLE_M) begin
          alu_func_d = {2'b10, funct3};
        end else begin
          illegal_d = 1'b1;
        end
      end
      c_OP_SYSTEM: begin
        // ebreak is the only SYSTEM encoding supported; ecall/csr* trap as illegal
        illegal_d = !ebreak_d;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // An illegal encoding must never produce side effects downstream.
  assign w_en_d   = w_en_raw && (in_inst[11:7] != 5'd0) && !illegal_d;
  assign mem_rd_d = mem_rd_raw && !illegal_d;
  assign mem_wr_d = mem_wr_raw && !illegal_d;
  assign jump_d   = jump_raw && !illegal_d;
  assign is_br_d  = is_br_raw && !illegal_d;

  // Pipeline register: flush beats accept, accept beats drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      rd_q       <= 5'd0;
      alu_func_q <= 5'd0;
      a_sel_q    <= 1'b0;
      b_sel_q    <= 1'b0;
      w_en_q     <= 1'b0;
      w_sel_q    <= 2'b00;
      jump_q     <= 1'b0;
      br_type_q  <= 3'd0;
      is_br_q    <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_size_q <= 3'd0;
      illegal_q  <= 1'b0;
      ebreak_q   <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q    <= 1'b1;
      pc_q       <= in_pc;
      imm_q      <= imm_d;
      rs1_q      <= in_inst[19:15];
      rs2_q      <= in_inst[24:20];
      rd_q       <= in_inst[11:7];
      alu_func_q <= alu_func_d;
      a_sel_q    <= a_sel_d;
      b_sel_q    <= b_sel_d;
      w_en_q     <= w_en_d;
      w_sel_q    <= w_sel_d;
      jump_q     <= jump_d;
      br_type_q  <= funct3;
      is_br_q    <= is_br_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      mem_size_q <= funct3;
      illegal_q  <= illegal_d;
      ebreak_q   <= ebreak_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Halt when an ebreak (or, optionally, an illegal op) actually enters the stage.
  assign halt_evt = accept && !flush && (ebreak_d || (HALT_ON_ILLEGAL && illegal_d));

  // RUN/HALT state register; only reset leaves HALT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // RUN/HALT next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (halt_evt) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  assign halted        = (state_q == ST_HALT);
  assign out_valid     = valid_q;
  assign out_pc        = pc_q;
  assign out_rs1       = rs1_q;
  assign out_rs2       = rs2_q;
  assign out_rd        = rd_q;
  assign out_imm       = imm_q;
  assign out_alu_a_sel = a_sel_q;
  assign out_alu_b_sel = b_sel_q;
  assign out_alu_func  = alu_func_q;
  assign out_w_en      = w_en_q;
  assign out_w_sel     = w_sel_q;
  assign out_jump_en   = jump_q;
  assign out_br_type   = br_type_q;
  assign out_is_branch = is_br_q;
  assign out_mem_rd    = mem_rd_q;
  assign out_mem_wr    = mem_wr_q;
  assign out_mem_size  = mem_size_q;
  assign out_illegal   = illegal_q;
  assign out_ebreak    = ebreak_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060240_idu_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060240_idu_stage
// Brief    : Self-checking bench for the registered decode stage: directed
//            scenarios plus a randomized stream scored against a decode model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060240_idu_stage;

  localparam int XLEN = 32;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ADDI5  = 32'h0050_0093;
  localparam logic [31:0] JALM8  = 32'hFF9F_F0EF;
  localparam logic [31:0] SW12   = 32'h0021_A623;
  localparam logic [31:0] MUL0   = 32'h0220_8033;
  localparam logic [6:0]  OPS [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
                                       7'h23, 7'h13, 7'h33, 7'h73, 7'h0f};

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        a, b;
    logic [4:0]  func;
    logic        wen;
    logic [1:0]  wsel;
    logic        jump;
    logic [2:0]  br;
    logic        isbr, mrd, mwr;
    logic [2:0]  msize;
    logic        ill, ebk;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [31:0] in_inst = 32'h0;
  logic [XLEN-1:0] in_pc = '0;
  logic in_ready, out_valid, out_alu_a_sel, out_alu_b_sel, out_w_en, out_jump_en;
  logic out_is_branch, out_mem_rd, out_mem_wr, out_illegal, out_ebreak, halted;
  logic [XLEN-1:0] out_pc, out_imm;
  logic [4:0] out_rs1, out_rs2, out_rd, out_alu_func;
  logic [1:0] out_w_sel;
  logic [2:0] out_br_type, out_mem_size;

  // second instance: no M extension, halts on illegal
  logic in_valid2 = 1'b0, flush2 = 1'b0;
  logic [31:0] in_inst2 = 32'h0;
  logic n_in_ready, n_valid, n_a, n_b, n_w_en, n_jump, n_isbr, n_mrd, n_mwr;
  logic n_illegal, n_ebreak, n_halted;
  logic [XLEN-1:0] n_pc, n_imm;
  logic [4:0] n_rs1, n_rs2, n_rd, n_func;
  logic [1:0] n_wsel;
  logic [2:0] n_br, n_msize;

  int n_checks = 0;
  int n_errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  ysyx_23060240_idu_stage #(.XLEN(XLEN), .ENABLE_M(1'b1), .HALT_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_alu_a_sel(out_alu_a_sel), .out_alu_b_sel(out_alu_b_sel),
    .out_alu_func(out_alu_func), .out_w_en(out_w_en), .out_w_sel(out_w_sel),
    .out_jump_en(out_jump_en), .out_br_type(out_br_type), .out_is_branch(out_is_branch),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_mem_size(out_mem_size),
    .out_illegal(out_illegal), .out_ebreak(out_ebreak), .halted(halted));

  ysyx_23060240_idu_stage #(.XLEN(XLEN), .ENABLE_M(1'b0), .HALT_ON_ILLEGAL(1'b1)) dut_nm (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(n_in_ready), .in_inst(in_inst2),
    .in_pc(in_pc), .flush(flush2), .out_valid(n_valid), .out_ready(1'b1),
    .out_pc(n_pc), .out_rs1(n_rs1), .out_rs2(n_rs2), .out_rd(n_rd),
    .out_imm(n_imm), .out_alu_a_sel(n_a), .out_alu_b_sel(n_b),
    .out_alu_func(n_func), .out_w_en(n_w_en), .out_w_sel(n_wsel),
    .out_jump_en(n_jump), .out_br_type(n_br), .out_is_branch(n_isbr),
    .out_mem_rd(n_mrd), .out_mem_wr(n_mwr), .out_mem_size(n_msize),
    .out_illegal(n_illegal), .out_ebreak(n_ebreak), .halted(n_halted));

  // Reference decode: classify the instruction, then derive each field from the ISA rules.
  function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc, input bit en_m);
    exp_t e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit legal;
    logic [4:0] alu_by_f3 [8];
    alu_by_f3 = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7}; // add sll slt sltu xor srl or and
    e = '0;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    e.pc = pc; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
    e.br = f3; e.msize = f3;
    e.ebk = (i == EBREAK);
    legal = 1'b0;
    case (op)
      7'h37: begin legal = 1; e.imm = i & 32'hFFFF_F000; e.func = 5'b01110; e.b = 1; e.wen = 1; e.wsel = 2; end
      7'h17: begin legal = 1; e.imm = i & 32'hFFFF_F000; e.b = 1; e.wen = 1; e.wsel = 2; end
      7'h6f: begin
        legal = 1; e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        e.b = 1; e.wen = 1; e.wsel = 1; e.jump = 1;
      end
      7'h67: begin
        legal = (f3 == 0); e.imm = 32'($signed(i[31:20]));
        e.a = 1; e.b = 1; e.wen = 1; e.wsel = 1; e.jump = 1;
      end
      7'h63: begin
        legal = !(f3 inside {3'd2, 3'd3}); e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        e.b = 1; e.isbr = 1;
      end
      7'h03: begin
        legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; e.imm = 32'($signed(i[31:20]));
        e.a = 1; e.b = 1; e.wen = 1; e.wsel = 3; e.mrd = 1;
      end
      7'h23: begin
        legal = (f3 <= 2); e.imm = 32'($signed({i[31:25], i[11:7]}));
        e.a = 1; e.b = 1; e.mwr = 1;
      end
      7'h13: begin
        e.imm = 32'($signed(i[31:20])); e.a = 1; e.b = 1; e.wen = 1; e.wsel = 2;
        if (f3 == 1) legal = (f7 == 0);
        else if (f3 == 5) legal = (f7 == 0) || (f7 == 7'h20);
        else legal = 1;
        e.func = alu_by_f3[f3] + ((f3 == 5 && f7 == 7'h20) ? 5'd8 : 5'd0);
      end
      7'h33: begin
        e.a = 1; e.wen = 1; e.wsel = 2;
        if (f7 == 0) begin legal = 1; e.func = alu_by_f3[f3]; end
        else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) begin legal = 1; e.func = alu_by_f3[f3] + 5'd8; end
        else if (f7 == 7'h01 && en_m) begin legal = 1; e.func = 5'd16 + 5'(f3); end
      end
      7'h73: legal = e.ebk;
      default: legal = 0;
    endcase
    if (!legal) begin e.ill = 1; e.wen = 0; e.mrd = 0; e.mwr = 0; e.jump = 0; end
    if (e.rd == 0) e.wen = 0;
    return e;
  endfunction

  // Copy fields whose value the decode rules leave open into the observation.
  function automatic exp_t mask_obs(input exp_t e, input exp_t o);
    exp_t m;
    m = o;
    if (e.ill || e.ebk) begin m.imm = e.imm; m.a = e.a; m.b = e.b; m.func = e.func; m.isbr = e.isbr; end
    if (e.ill) m.wsel = e.wsel;
    if (!e.ill && e.func == 5'b01110) m.a = e.a;
    if (e.ill || !e.isbr) m.br = e.br;
    if (e.ill || !(e.mrd || e.mwr)) m.msize = e.msize;
    return m;
  endfunction

  function automatic exp_t get_obs();
    exp_t o;
    o.pc = out_pc; o.rs1 = out_rs1; o.rs2 = out_rs2; o.rd = out_rd; o.imm = out_imm;
    o.a = out_alu_a_sel; o.b = out_alu_b_sel; o.func = out_alu_func; o.wen = out_w_en;
    o.wsel = out_w_sel; o.jump = out_jump_en; o.br = out_br_type; o.isbr = out_is_branch;
    o.mrd = out_mem_rd; o.mwr = out_mem_wr; o.msize = out_mem_size;
    o.ill = out_illegal; o.ebk = out_ebreak;
    return o;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 11);
    if (k < 11) r[6:0] = OPS[k];
    if (r[6:0] == 7'h33 || r[6:0] == 7'h13) begin
      case ($urandom_range(0, 3))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        2: r[31:25] = 7'h01;
        default: ;
      endcase
    end
    if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
    if (r == EBREAK) r = 32'h0000_0073;
    return r;
  endfunction

  // Stimulus only: present one instruction for one cycle with the consumer ready.
  task automatic drive_one(input logic [31:0] inst, input logic [31:0] pc);
    @(negedge clk);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; out_ready = 1'b1; flush = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic go_idle();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || halted !== 1'b0 || n_halted !== 1'b0)
      begin n_errors++; $display("FAIL reset_flags valid=%b halted=%b n_halted=%b expected 0/0/0", out_valid, halted, n_halted); end
    n_checks++;
    if (get_obs() !== exp_t'(0))
      begin n_errors++; $display("FAIL reset_bundle got=%h expected all zero", get_obs()); end
    n_checks++;
    if (in_ready !== 1'b1)
      begin n_errors++; $display("FAIL reset_in_ready got=%b expected 1", in_ready); end
  endtask

  task automatic test_addi();
    exp_t e, o;
    go_idle();
    drive_one(ADDI5, 32'h8000_0000);
    n_checks++;
    if (out_valid !== 1 || out_rd !== 5'd1 || out_imm !== 32'd5 || out_alu_func !== 5'b00000 ||
        out_alu_b_sel !== 1 || out_w_en !== 1 || out_w_sel !== 2'b10 || out_pc !== 32'h8000_0000)
      begin n_errors++; $display("FAIL addi got v=%b rd=%0d imm=%h f=%b b=%b wen=%b wsel=%b pc=%h expected 1/1/5/00000/1/1/10/80000000",
        out_valid, out_rd, out_imm, out_alu_func, out_alu_b_sel, out_w_en, out_w_sel, out_pc); end
    e = ref_decode(ADDI5, 32'h8000_0000, 1'b1);
    o = mask_obs(e, get_obs());
    n_checks++;
    if (o !== e) begin n_errors++; $display("FAIL addi_model got=%h expected=%h", o, e); end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL drain_valid got=%b expected 0", out_valid); end
  endtask

  task automatic test_jal_sw();
    go_idle();
    drive_one(JALM8, 32'h0000_1000);
    n_checks++;
    if (out_imm !== 32'hFFFF_FFF8 || out_alu_a_sel !== 0 || out_jump_en !== 1 || out_w_sel !== 2'b01 || out_w_en !== 1)
      begin n_errors++; $display("FAIL jal got imm=%h a=%b j=%b wsel=%b wen=%b expected fffffff8/0/1/01/1",
        out_imm, out_alu_a_sel, out_jump_en, out_w_sel, out_w_en); end
    drive_one(SW12, 32'h0000_1004);
    n_checks++;
    if (out_imm !== 32'd12 || out_mem_wr !== 1 || out_w_en !== 0 || out_mem_size !== 3'b010 ||
        out_rs1 !== 5'd3 || out_rs2 !== 5'd2)
      begin n_errors++; $display("FAIL sw got imm=%h mwr=%b wen=%b size=%b rs1=%0d rs2=%0d expected 12/1/0/010/3/2",
        out_imm, out_mem_wr, out_w_en, out_mem_size, out_rs1, out_rs2); end
  endtask

  task automatic test_mul();
    go_idle();
    drive_one(MUL0, 32'h0000_2000);
    n_checks++;
    if (out_alu_func !== 5'b10000 || out_w_en !== 0 || out_illegal !== 0 || out_alu_b_sel !== 0)
      begin n_errors++; $display("FAIL mul_m got f=%b wen=%b ill=%b b=%b expected 10000/0/0/0",
        out_alu_func, out_w_en, out_illegal, out_alu_b_sel); end
    @(negedge clk);
    in_valid2 = 1'b1; in_inst2 = MUL0;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    n_checks++;
    if (n_valid !== 1 || n_illegal !== 1 || n_w_en !== 0 || n_halted !== 1 || n_in_ready !== 0)
      begin n_errors++; $display("FAIL mul_no_m got v=%b ill=%b wen=%b halted=%b rdy=%b expected 1/1/0/1/0",
        n_valid, n_illegal, n_w_en, n_halted, n_in_ready); end
    @(negedge clk);
    flush2 = 1'b1;
    @(posedge clk); #1;
    flush2 = 1'b0;
    n_checks++;
    if (n_halted !== 1 || n_valid !== 0)
      begin n_errors++; $display("FAIL flush_in_halt got halted=%b v=%b expected 1/0", n_halted, n_valid); end
    @(negedge clk);
    in_valid2 = 1'b1; in_inst2 = ADDI5;
    #1;
    n_checks++;
    if (n_in_ready !== 0) begin n_errors++; $display("FAIL halt_ready got=%b expected 0", n_in_ready); end
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    n_checks++;
    if (n_valid !== 0) begin n_errors++; $display("FAIL halt_accept got v=%b expected 0", n_valid); end
  endtask

  task automatic test_ebreak();
    go_idle();
    @(negedge clk);
    in_valid = 1'b1; in_inst = EBREAK; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1 || out_ebreak !== 1 || halted !== 1 || in_ready !== 0 || out_w_en !== 0)
      begin n_errors++; $display("FAIL ebreak got v=%b ebk=%b halted=%b rdy=%b wen=%b expected 1/1/1/0/0",
        out_valid, out_ebreak, halted, in_ready, out_w_en); end
    @(negedge clk);
    in_valid = 1'b1; in_inst = ADDI5; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 0) begin n_errors++; $display("FAIL halt_in_ready got=%b expected 0", in_ready); end
    @(negedge clk);
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (halted !== 0 || out_valid !== 0 || n_halted !== 0)
      begin n_errors++; $display("FAIL async_reset got halted=%b v=%b n_halted=%b expected 0/0/0", halted, out_valid, n_halted); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1) begin n_errors++; $display("FAIL post_reset_ready got=%b expected 1", in_ready); end
  endtask

  task automatic test_flush();
    go_idle();
    @(negedge clk);
    in_valid = 1'b1; in_inst = 32'h00A0_0113; flush = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1) begin n_errors++; $display("FAIL flush_ready got=%b expected 1", in_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 0) begin n_errors++; $display("FAIL flush_accept got v=%b expected 0", out_valid); end
    @(negedge clk);
    flush = 1'b0; in_inst = 32'h0070_0193; in_pc = 32'h44;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1 || out_rd !== 5'd3 || out_imm !== 32'd7 || out_pc !== 32'h44)
      begin n_errors++; $display("FAIL after_flush got v=%b rd=%0d imm=%h pc=%h expected 1/3/7/44", out_valid, out_rd, out_imm, out_pc); end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (out_valid !== 0) begin n_errors++; $display("FAIL flush_held got v=%b expected 0", out_valid); end
  endtask

  task automatic test_stall();
    logic [31:0] insts [4];
    int idx, pops;
    bit exp_rdy;
    exp_t e, o;
    insts = '{32'h0010_0093, 32'h0021_A623, 32'h4020_81B3, 32'h0000_2237};
    go_idle();
    q.delete();
    idx = 0; pops = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = (idx < 4); in_inst = insts[idx % 4]; in_pc = 32'h100 + 4 * idx;
      out_ready = !(c == 2 || c == 3); flush = 1'b0;
      #1;
      exp_rdy = (q.size() == 0) || out_ready;
      n_checks++;
      if (out_valid !== (q.size() != 0) || in_ready !== exp_rdy)
        begin n_errors++; $display("FAIL stall_hs cyc=%0d got v=%b rdy=%b expected %b/%b", c, out_valid, in_ready, q.size() != 0, exp_rdy); end
      if (q.size() != 0 && out_ready) begin
        e = q.pop_front(); o = mask_obs(e, get_obs()); pops++;
        n_checks++;
        if (o !== e) begin n_errors++; $display("FAIL stall_bundle got=%h expected=%h", o, e); end
      end
      if (in_valid && exp_rdy) begin q.push_back(ref_decode(in_inst, in_pc, 1'b1)); idx++; end
    end
    n_checks++;
    if (pops != 4 || idx != 4) begin n_errors++; $display("FAIL stall_count got pops=%0d sent=%0d expected 4/4", pops, idx); end
  endtask

  task automatic test_random(input int n, input int p_valid, input int p_ready, input bit allow_flush);
    bit exp_rdy;
    exp_t e, o;
    go_idle();
    q.delete();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 99) < p_valid); in_inst = rand_inst(); in_pc = $urandom & 32'hFFFF_FFFC;
      out_ready = ($urandom_range(0, 99) < p_ready); flush = allow_flush && ($urandom_range(0, 15) == 0);
      #1;
      exp_rdy = (q.size() == 0) || out_ready;
      n_checks++;
      if (out_valid !== (q.size() != 0) || in_ready !== exp_rdy || halted !== 0)
        begin n_errors++; $display("FAIL rand_hs cyc=%0d got v=%b rdy=%b h=%b expected %b/%b/0", c, out_valid, in_ready, halted, q.size() != 0, exp_rdy); end
      if (q.size() != 0 && out_ready && !flush) begin
        e = q.pop_front(); o = mask_obs(e, get_obs());
        n_checks++;
        if (o !== e) begin n_errors++; $display("FAIL rand_bundle got=%h expected=%h", o, e); end
      end
      if (flush) q.delete();
      if (in_valid && exp_rdy && !flush) q.push_back(ref_decode(in_inst, in_pc, 1'b1));
    end
  endtask

  task automatic test_back_to_back();
    test_random(24, 100, 100, 1'b0);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_jal_sw();
    test_mul();
    test_ebreak();
    test_flush();
    test_stall();
    test_random(600, 75, 70, 1'b1);
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after 500000 time units");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ysyx_23060240_idu_stage.md
Name: ysyx_23060240_idu_stage

Overview:
Registered RV32I(+M) decode stage between IFU and EXU, replacing the purely combinational decoder.
- Decodes one instruction per cycle into a pipeline register, using a valid/ready handshake on both sides.
- Adds full immediate generation, register-index extraction, branch/memory control, illegal-instruction detection, flush, and an ebreak halt FSM that replaces the DPI trap call.

Parameters:
XLEN, 32, width of pc and immediate datapath; immediates sign-extended to XLEN
ENABLE_M, 1, 1 = decode RV32M (mul/div/rem); 0 = M encodings flagged illegal
HALT_ON_ILLEGAL, 0, 1 = an accepted illegal instruction also enters HALT

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  IFU holds valid instruction
in_ready  out  1  stage accepts this cycle
in_inst  in  32  instruction word
in_pc  in  XLEN  instruction pc
flush  in  1  drop registered instruction (redirect)
out_valid  out  1  decoded bundle valid
out_ready  in  1  EXU consumes bundle
out_pc  out  XLEN  registered pc
out_rs1, out_rs2, out_rd  out  5 each  inst[19:15], inst[24:20], inst[11:7]
out_imm  out  XLEN  sign-extended I/S/B/U/J immediate (0 for R-type)
out_alu_a_sel  out  1  1 = rs1, 0 = pc
out_alu_b_sel  out  1  1 = imm, 0 = rs2
out_alu_func  out  5  ALU op code
out_w_en  out  1  register write enable
out_w_sel  out  2  00 none, 01 pc+4, 10 ALU, 11 memory
out_jump_en  out  1  jal/jalr
out_br_type  out  3  funct3 of branch; valid only when out_is_branch
out_is_branch  out  1  B-type
out_mem_rd, out_mem_wr  out  1 each  load / store
out_mem_size  out  3  funct3 of load/store
out_illegal  out  1  unsupported encoding
out_ebreak  out  1  inst == 0x00100073
halted  out  1  FSM in HALT

Behaviour:
- Reset values: out_valid = 0, halted = 0, and every registered bundle field = 0. Reset applies immediately (async) and overrides an in-flight handshake.
- Handshakes:
  - in_ready = !halted && (!out_valid || out_ready), a combinational path.
  - Accept = in_valid && in_ready. On accept, the decoded bundle is registered and out_valid = 1 next cycle. Latency is 1 cycle.
  - out_valid && !out_ready: the bundle holds stable and in_ready = 0.
  - out_valid && out_ready && !in_valid: out_valid goes to 0 next cycle.
  - Back-to-back accept + consume in the same cycle gives full throughput.
- flush: out_valid goes to 0 next cycle, and any same-cycle accept is discarded (flush has priority). in_ready is unaffected by flush.
- FSM RUN/HALT:
  - RUN -> HALT on the cycle an ebreak is accepted, or an illegal instruction is accepted when HALT_ON_ILLEGAL = 1.
  - The ebreak bundle itself is still presented with out_valid = 1.
  - HALT is exited only by rst. A flush in HALT does not leave HALT.
- ALU codes:
  - add 00000, sub 01000, sll 00001, slt 00010, sltu 00011, xor 00100, srl 00101, or 00110, and 00111, sra 01101, pass-B (lui) 01110.
  - M ops: 1_0_funct3, i.e. mul 10000 ... remu 10111.
  - add is used by auipc, jal, jalr, loads, stores, add, and addi.
  - Branches use code 00000; compare is done in EXU via out_br_type.
- Operand selects:
  - alu_a_sel = 1 for I, S, and R-type; 0 for auipc, jal, and branches.
  - alu_b_sel = 0 only for R-type, including M ops.
- Write control:
  - w_en = 1 for U, J, I, R, and M ops, except that it is forced to 0 when rd = 0 or illegal.
  - w_sel: jal/jalr = 01; ALU results = 10; loads = 11; otherwise 00.
- Illegal: any opcode/funct3/funct7 combination not listed above, including M ops when ENABLE_M = 0. ecall (0x00000073) is illegal. Illegal instructions force w_en, mem_rd, mem_wr, and jump_en to 0.
- Shift-immediate instructions with funct7 other than 0x00/0x20 (srai) are illegal.

Test Plan:
- addi x1,x0,5 (0x00500093), out_ready = 1 -> next cycle: out_valid = 1, rd = 1, imm = 5, alu_func = 00000, b_sel = 1, w_en = 1, w_sel = 10.
- Stream of 4 instructions with out_ready low in cycles 2–3 -> bundle held stable, in_ready = 0; no drop or duplicate, order preserved, 4 bundles total.
- jal x1,-8 (0xFF9FF0EF) -> imm = 0xFFFFFFF8, a_sel = 0, jump_en = 1, w_sel = 01; sw x2,12(x3) (0x0021A623) -> imm = 12, mem_wr = 1, w_en = 0.
- mul x0,x1,x2 (0x02208033): with ENABLE_M = 1 -> alu_func = 10000, w_en = 0 (rd = 0). With ENABLE_M = 0 -> illegal = 1.
- ebreak (0x00100073) accepted -> out_ebreak = 1, halted = 1 next cycle, in_ready = 0 thereafter; assert rst -> halted = 0, out_valid = 0 immediately.
- flush asserted in the same cycle as an accept -> out_valid = 0 next cycle; the subsequent instruction decodes normally.
